request_unit: RTL and testbench

- Sequences memory requests for the single-cycle RISC-V core. Sits directly downstream of control_unit.
- Consumes the decoded dmemr/dmemw/halt strobes. Drives imemREN/dmemREN/dmemWEN toward the memory controller.
- Pulses pc_en when the current instruction retires. Parks the core on halt.
- Holds data requests stable until dhit, so the datapath never drops an outstanding access.

---
 rtl/request_unit_if.sv | 38 +++
 rtl/request_unit.sv | 153 +++++++++++++++
 tb/tb_request_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/request_unit_if.sv
// Request-unit bus: decoded strobes from control_unit and memory hits in,
// memory request enables and core status out.
// Optional macro: REQUEST_PERF_EN adds the instr_count/stall_count counters.
interface request_unit_if;
    logic        ihit;
    logic        dhit;
    logic        dmemr;
    logic        dmemw;
    logic        halt;
    logic        imemREN;
    logic        dmemREN;
    logic        dmemWEN;
    logic        pc_en;
    logic        halt_out;
    logic        req_err;
`ifdef REQUEST_PERF_EN
    logic [31:0] instr_count;
    logic [31:0] stall_count;
`endif

    // Request unit side
    modport master (
        input  ihit, dhit, dmemr, dmemw, halt,
        output imemREN, dmemREN, dmemWEN, pc_en, halt_out, req_err
`ifdef REQUEST_PERF_EN
        , output instr_count, stall_count
`endif
    );

    // Environment side (control unit, memory controller)
    modport slave (
        output ihit, dhit, dmemr, dmemw, halt,
        input  imemREN, dmemREN, dmemWEN, pc_en, halt_out, req_err
`ifdef REQUEST_PERF_EN
        , input instr_count, stall_count
`endif
    );
endinterface

// File: rtl/request_unit.sv
// request_unit: sequences instruction fetches and data accesses for the
// single-cycle core, pulses pc_en on retirement and parks the core on HALT.
// Data requests are registered and held until dhit; a watchdog flags a data
// access that stalls for STALL_LIMIT cycles (the request is still held).
// Optional macro: REQUEST_PERF_EN adds instr_count and stall_count.
module request_unit #(
    parameter int unsigned STALL_LIMIT = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    request_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA, HALTED} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

    state_t           state_q, state_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             err_q, err_d;

    logic fetch_hit;
    logic mem_op;
    logic take_mem;
    logic data_stall;
    logic imem_ren;
    logic dmem_ren;
    logic dmem_wen;
    logic pc_en;
    logic halted;

    assign fetch_hit  = (state_q == FETCH) && bus.ihit;
    assign mem_op     = bus.dmemr | bus.dmemw;
    // A fetched load/store only starts a data access when HALT is not also set
    assign take_mem   = fetch_hit && !bus.halt && mem_op;
    assign data_stall = (state_q == DATA) && !bus.dhit;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH: begin
                if (fetch_hit) begin
                    if (bus.halt)   state_d = HALTED;
                    else if (mem_op) state_d = DATA;
                end
            end
            DATA:    if (bus.dhit) state_d = FETCH;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: imemREN by state, data enables from the latched request, pc_en Mealy
    always_comb begin
        imem_ren = 1'b0;
        dmem_ren = 1'b0;
        dmem_wen = 1'b0;
        pc_en    = 1'b0;
        halted   = 1'b0;
        case (state_q)
            FETCH: begin
                imem_ren = 1'b1;
                pc_en    = bus.ihit && !bus.halt && !mem_op;
            end
            DATA: begin
                dmem_ren = rd_q;
                dmem_wen = wr_q;
                pc_en    = bus.dhit;
            end
            HALTED:  halted = 1'b1;
            default: ;
        endcase
    end

    // Request latch, watchdog and error flag next-state; store wins over load
    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        wdog_d = '0;
        err_d  = err_q;
        if (take_mem) begin
            rd_d = bus.dmemr & ~bus.dmemw;
            wr_d = bus.dmemw;
            if (bus.dmemr && bus.dmemw) err_d = 1'b1;
        end else if ((state_q == DATA) && bus.dhit) begin
            rd_d = 1'b0;
            wr_d = 1'b0;
        end
        if (data_stall) begin
            wdog_d = (wdog_q >= LIMIT) ? wdog_q : wdog_q + CNT_W'(1);
            if (wdog_d == LIMIT) err_d = 1'b1;
        end
    end

    // Request latch, watchdog and sticky error registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign bus.imemREN  = imem_ren;
    assign bus.dmemREN  = dmem_ren;
    assign bus.dmemWEN  = dmem_wen;
    assign bus.pc_en    = pc_en;
    assign bus.halt_out = halted;
    assign bus.req_err  = err_q;

`ifdef REQUEST_PERF_EN
    logic [31:0] instr_q, instr_d;
    logic [31:0] stall_q, stall_d;

    // Retirement and stall counters; both naturally freeze in HALTED
    always_comb begin
        instr_d = instr_q + (pc_en ? 32'd1 : 32'd0);
        stall_d = stall_q;
        if (((state_q == FETCH) && !bus.ihit) || data_stall)
            stall_d = stall_q + 32'd1;
    end

    // Performance counter registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            instr_q <= instr_d;
            stall_q <= stall_d;
        end
    end

    assign bus.instr_count = instr_q;
    assign bus.stall_count = stall_q;
`endif
endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit (STALL_LIMIT=4): a vector table from
// reset, hand sequences for watchdog/illegal/halt/async-reset corners, then
// random stimulus against a transaction-level reference model.
module tb_request_unit;
    localparam int LIMIT = 4;

    logic CLK;
    logic nRST;
    int   total = 0;
    int   bad   = 0;

    request_unit_if bus();

    request_unit #(.STALL_LIMIT(LIMIT), .CNT_W(8)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit       ih, dh, r, w, h;
        bit [5:0] e;   // {imemREN, dmemREN, dmemWEN, pc_en, halt_out, req_err}
    } vec_t;

    vec_t tbl[14];

    function automatic logic [5:0] outs();
        return {bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.pc_en, bus.halt_out, bus.req_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic apply(input bit ih, input bit dh, input bit r, input bit w, input bit h);
        bus.ihit  = ih;
        bus.dhit  = dh;
        bus.dmemr = r;
        bus.dmemw = w;
        bus.halt  = h;
    endtask

    // Sample at the falling edge, then advance to just after the next rising edge
    task automatic tick(input string name, input logic [5:0] exp);
        @(negedge CLK);
        chk(name, {26'd0, outs()}, {26'd0, exp});
        @(posedge CLK);
        #1;
    endtask

    // Leaves the DUT in IDLE, just after a rising edge
    task automatic do_reset();
        nRST = 1'b0;
        apply(0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("reset_outs", {26'd0, outs()}, 32'd0);
`ifdef REQUEST_PERF_EN
        chk("reset_instr", bus.instr_count, 32'd0);
        chk("reset_stall", bus.stall_count, 32'd0);
`endif
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    // Reference model state
    bit          m_boot, m_halt, m_err;
    int          m_pend;   // 0 none, 1 load, 2 store
    int          m_wait;
    int unsigned m_instr, m_stall;

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_err = 0; m_pend = 0; m_wait = 0;
        m_instr = 0; m_stall = 0;
    endtask

    initial begin
        bit ih, dh, r, w, h;
        logic [5:0] e;

        nRST = 1'b0;
        apply(0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;

        tbl[0]  = '{0, 0, 0, 0, 0, 6'b000000};  // IDLE after release
        tbl[1]  = '{1, 0, 0, 0, 0, 6'b100100};  // ADD retires
        tbl[2]  = '{0, 0, 0, 0, 0, 6'b100000};  // waiting for ihit
        tbl[3]  = '{1, 1, 0, 0, 0, 6'b100100};  // dhit in FETCH ignored
        tbl[4]  = '{1, 0, 1, 0, 0, 6'b100000};  // load fetched
        tbl[5]  = '{0, 0, 0, 0, 0, 6'b010000};  // read held
        tbl[6]  = '{1, 0, 0, 0, 0, 6'b010000};  // ihit in DATA ignored
        tbl[7]  = '{0, 0, 0, 0, 0, 6'b010000};
        tbl[8]  = '{0, 1, 0, 0, 0, 6'b010100};  // load retires on dhit
        tbl[9]  = '{0, 0, 0, 0, 0, 6'b100000};
        tbl[10] = '{1, 0, 0, 1, 0, 6'b100000};  // store fetched
        tbl[11] = '{0, 1, 0, 0, 0, 6'b001100};  // store retires, 2 cycles
        tbl[12] = '{0, 0, 0, 0, 0, 6'b100000};
        tbl[13] = '{1, 0, 0, 0, 0, 6'b100100};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].ih, tbl[i].dh, tbl[i].r, tbl[i].w, tbl[i].h);
            tick($sformatf("vec%0d", i), tbl[i].e);
        end

        // Store stalls past the watchdog limit; request held, error sticky
        do_reset();
        apply(0, 0, 0, 0, 0); tick("wd_idle", 6'b000000);
        apply(1, 0, 0, 1, 0); tick("wd_fetch", 6'b100000);
        for (int k = 0; k < 6; k++) begin
            apply(0, 0, 0, 0, 0);
            tick($sformatf("wd_hold%0d", k), {5'b00100, (k >= LIMIT) ? 1'b1 : 1'b0});
        end
        apply(0, 1, 0, 0, 0); tick("wd_dhit", 6'b001101);
        apply(0, 0, 0, 0, 0); tick("wd_after", 6'b100001);

        // dmemr & dmemw together: store with error
        do_reset();
        apply(0, 0, 0, 0, 0); tick("ill_idle", 6'b000000);
        apply(1, 0, 1, 1, 0); tick("ill_fetch", 6'b100000);
        apply(0, 0, 0, 0, 0); tick("ill_data", 6'b001001);
        apply(0, 1, 0, 0, 0); tick("ill_dhit", 6'b001101);

        // HALT wins over a load; halted core ignores hits until reset
        do_reset();
        apply(0, 0, 0, 0, 0); tick("h_idle", 6'b000000);
        apply(1, 0, 1, 0, 1); tick("h_fetch", 6'b100000);
        for (int k = 0; k < 4; k++) begin
            apply(k[0], !k[0], 0, 0, 0);
            tick($sformatf("h_park%0d", k), 6'b000010);
        end
        nRST = 1'b0;
        #1;
        chk("h_async_clear", {26'd0, outs()}, 32'd0);
        @(posedge CLK); #1;

        // Async reset mid-DATA drops dmemWEN before the next edge
        do_reset();
        apply(0, 0, 0, 0, 0); tick("ar_idle", 6'b000000);
        apply(1, 0, 0, 1, 0); tick("ar_fetch", 6'b100000);
        apply(0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("ar_wen", {26'd0, outs()}, {26'd0, 6'b001000});
        #2 nRST = 1'b0;
        #1 chk("ar_drop", {26'd0, outs()}, 32'd0);
        @(posedge CLK); #1;

`ifdef REQUEST_PERF_EN
        // 5 retirements and 3 stall cycles
        do_reset();
        apply(0, 0, 0, 0, 0); tick("pf_idle", 6'b000000);
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 0, 0, 0); tick("pf_add", 6'b100100);
        end
        apply(0, 0, 0, 0, 0); tick("pf_s1", 6'b100000);
        apply(0, 0, 0, 0, 0); tick("pf_s2", 6'b100000);
        apply(1, 0, 1, 0, 0); tick("pf_ld", 6'b100000);
        apply(0, 0, 0, 0, 0); tick("pf_s3", 6'b010000);
        apply(0, 1, 0, 0, 0); tick("pf_ret", 6'b010100);
        apply(1, 0, 0, 0, 0); tick("pf_add5", 6'b100100);
        @(negedge CLK);
        chk("pf_instr", bus.instr_count, 32'd5);
        chk("pf_stall", bus.stall_count, 32'd3);
        @(posedge CLK); #1;
`endif

        // Random stimulus against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                model_reset();
            end
            ih = ($urandom_range(0, 1) == 1);
            dh = ($urandom_range(0, 9) < 4);
            r  = ($urandom_range(0, 4) == 0);
            w  = ($urandom_range(0, 4) == 0);
            h  = ($urandom_range(0, 63) == 0);
            apply(ih, dh, r, w, h);

            if (m_halt)          e = {5'b00001, m_err};
            else if (m_boot)     e = {5'b00000, m_err};
            else if (m_pend != 0) e = {1'b0, m_pend == 1, m_pend == 2, dh, 1'b0, m_err};
            else                 e = {1'b1, 1'b0, 1'b0, ih && !h && !r && !w, 1'b0, m_err};

            @(negedge CLK);
            chk($sformatf("rnd%0d", n), {26'd0, outs()}, {26'd0, e});
`ifdef REQUEST_PERF_EN
            chk($sformatf("rnd%0d_instr", n), bus.instr_count, m_instr);
            chk($sformatf("rnd%0d_stall", n), bus.stall_count, m_stall);
`endif
            if (!m_halt) begin
                if (m_boot) begin
                    m_boot = 0;
                end else if (m_pend != 0) begin
                    if (dh) begin
                        m_instr++;
                        m_pend = 0;
                        m_wait = 0;
                    end else begin
                        m_stall++;
                        if (m_wait < LIMIT) m_wait++;
                        if (m_wait == LIMIT) m_err = 1;
                    end
                end else if (ih) begin
                    if (h) m_halt = 1;
                    else if (w) begin
                        m_pend = 2;
                        if (r) m_err = 1;
                    end else if (r) m_pend = 1;
                    else m_instr++;
                end else begin
                    m_stall++;
                end
            end
            @(posedge CLK);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
